// File: rtl/regfile_scoreboard.sv
// Two-read/one-write integer register file with write-to-read bypass, hardwired zero register
// and a per-register busy scoreboard. Define REGFILE_SYNC_READ_EN for registered (1-cycle) reads.
module regfile_scoreboard #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  output logic            ready1,
  output logic            ready2,
  output logic            busy_any
);

  localparam int          IW      = $clog2(NREGS);
  localparam logic [AW:0] NREGS_W = NREGS[AW:0];

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            ready;
  } rd_t;

  // An address is "live" when it names a real, writable register.
  function automatic logic live(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW-1:0]    ra [2];
  rd_t              rd_out [2];

  assign ra[0] = rs1;
  assign ra[1] = rs2;

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (wr_en && live(wr_addr))
      busy_next[wr_addr[IW-1:0]] = 1'b0;
    // Applied after the clear so a same-cycle alloc of the written register wins.
    if (alloc_en && live(alloc_addr))
      busy_next[alloc_addr[IW-1:0]] = 1'b1;
  end

  // NOTE: the storage array is reset explicitly because the block must read all-zero right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_en && live(wr_addr))
        regs[wr_addr[IW-1:0]] <= wr_data;
      busy <= busy_next;
    end
  end

`ifdef REGFILE_SYNC_READ_EN
  rd_t rd_q [2];

  // Write-first: a same-edge write is forwarded, ready reflects the post-edge scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) rd_q[p] <= '{data: '0, ready: 1'b1};
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (!live(ra[p]))
          rd_q[p] <= '{data: '0, ready: 1'b1};
        else if (wr_en && (wr_addr == ra[p]))
          rd_q[p] <= '{data: wr_data, ready: !busy_next[ra[p][IW-1:0]]};
        else
          rd_q[p] <= '{data: regs[ra[p][IW-1:0]], ready: !busy_next[ra[p][IW-1:0]]};
      end
    end
  end

  assign rd_out[0] = rd_q[0];
  assign rd_out[1] = rd_q[1];
`else
  rd_t rd_comb [2];

  // Reset forces zero/ready and suppresses the bypass path.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_comb[p] = '{data: '0, ready: 1'b1};
      if (!reset && live(ra[p])) begin
        if (wr_en && (wr_addr == ra[p]))
          rd_comb[p] = '{data: wr_data, ready: 1'b1};
        else
          rd_comb[p] = '{data: regs[ra[p][IW-1:0]], ready: !busy[ra[p][IW-1:0]]};
      end
    end
  end

  assign rd_out[0] = rd_comb[0];
  assign rd_out[1] = rd_comb[1];
`endif

  assign readData1 = rd_out[0].data;
  assign ready1    = rd_out[0].ready;
  assign readData2 = rd_out[1].data;
  assign ready2    = rd_out[1].ready;
  assign busy_any  = |busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (default combinational-read build):
// directed scenarios plus random traffic checked against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] readData1;
  logic [63:0] readData2;
  logic        ready1;
  logic        ready2;
  logic        busy_any;

  int tests    = 0;
  int failures = 0;

  logic [63:0] m_regs [32];
  bit          m_busy [32];

  regfile_scoreboard #(.XLEN(64), .NREGS(32), .AW(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .rs1(rs1), .rs2(rs2),
    .readData1(readData1), .readData2(readData2),
    .ready1(ready1), .ready2(ready2), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // Expected {ready, data} for a read of address a given the currently driven write port.
  function automatic logic [64:0] model_read(input logic [4:0] a);
    if (a == 5'd0)                   return {1'b1, 64'd0};
    if (wr_en && wr_addr == a)       return {1'b1, wr_data};
    return {!m_busy[a], m_regs[a]};
  endfunction

  function automatic logic model_busy_any();
    logic b = 1'b0;
    for (int i = 0; i < 32; i++) b |= m_busy[i];
    return b;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic ae, input logic [4:0] aa,
                       input logic [4:0] r1, input logic [4:0] r2);
    wr_en = we; wr_addr = wa; wr_data = wd;
    alloc_en = ae; alloc_addr = aa;
    rs1 = r1; rs2 = r2;
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [64:0] e1, e2;
    e1 = model_read(rs1);
    e2 = model_read(rs2);
    check({tag, ".d1"}, readData1, e1[63:0]);
    check({tag, ".r1"}, {63'd0, ready1}, {63'd0, e1[64]});
    check({tag, ".d2"}, readData2, e2[63:0]);
    check({tag, ".r2"}, {63'd0, ready2}, {63'd0, e2[64]});
    check({tag, ".busy"}, {63'd0, busy_any}, {63'd0, model_busy_any()});
  endtask

  // Clock edge, then apply the architectural rules to the model: write clears, alloc sets (and wins).
  task automatic tick();
    @(posedge clk);
    if (wr_en && wr_addr != 5'd0) begin
      m_regs[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycle(input string tag, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic ae, input logic [4:0] aa,
                       input logic [4:0] r1, input logic [4:0] r2);
    drive(we, wa, wd, ae, aa, r1, r2);
    check_model(tag);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    model_clear();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    #2;
    check("rst.d1", readData1, 64'd0);
    check("rst.d2", readData2, 64'd0);
    check("rst.r1", {63'd0, ready1}, 64'd1);
    check("rst.r2", {63'd0, ready2}, 64'd1);
    check("rst.busy", {63'd0, busy_any}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Write then read back.
    cycle("wr5", 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 5'd0, 5'd1, 5'd2);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    check_model("rd5");
    check("rd5.const", readData1, 64'hDEAD_BEEF);
    tick();

    // Same-cycle bypass to both ports, then stored value after the edge.
    drive(1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 5'd7, 5'd7);
    check_model("byp7");
    check("byp7.d1c", readData1, 64'h1234);
    check("byp7.d2c", readData2, 64'h1234);
    tick();
    cycle("rd7", 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd7);

    // Register 0 ignores writes and allocs.
    cycle("z0", 1'b1, 5'd0, 64'hFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("z0.d1c", readData1, 64'd0);
    check("z0.busyc", {63'd0, busy_any}, 64'd0);
    tick();

    // Alloc 9, observe pending, writeback clears.
    cycle("al9", 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd0, 5'd9);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    check("al9.r2c", {63'd0, ready2}, 64'd0);
    check("al9.busyc", {63'd0, busy_any}, 64'd1);
    tick();
    drive(1'b1, 5'd9, 64'd42, 1'b0, 5'd0, 5'd0, 5'd9);
    check_model("wb9");
    check("wb9.d2c", readData2, 64'd42);
    check("wb9.r2c", {63'd0, ready2}, 64'd1);
    tick();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    check("wb9.busyc", {63'd0, busy_any}, 64'd0);
    tick();

    // Alloc and write the same register on one edge: alloc wins.
    cycle("aw3", 1'b1, 5'd3, 64'd77, 1'b1, 5'd3, 5'd3, 5'd0);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    check_model("aw3p");
    check("aw3.d1c", readData1, 64'd77);
    check("aw3.r1c", {63'd0, ready1}, 64'd0);
    check("aw3.busyc", {63'd0, busy_any}, 64'd1);
    tick();

    // Mid-operation reset with a write in flight and pending allocs.
    cycle("ld4", 1'b1, 5'd4, 64'h55, 1'b1, 5'd6, 5'd4, 5'd6);
    drive(1'b1, 5'd4, 64'h99, 1'b1, 5'd8, 5'd4, 5'd6);
    reset = 1'b1;
    #1;
    check("mrst.d1", readData1, 64'd0);
    check("mrst.r1", {63'd0, ready1}, 64'd1);
    check("mrst.r2", {63'd0, ready2}, 64'd1);
    check("mrst.busy", {63'd0, busy_any}, 64'd0);
    reset = 1'b0;
    model_clear();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd6);
    check_model("mrst.after");
    check("mrst.d1after", readData1, 64'd0);
    tick();

    // Random traffic, addresses biased towards a small set to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, aa, r1, r2;
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      aa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 5));
      cycle("rnd", 1'($urandom_range(0, 1)), wa, {$urandom(), $urandom()},
            1'($urandom_range(0, 1)), aa, r1, r2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
